fsm16bit_seq: RTL

Step sequencer for the 16-bit counter FSM. A single start strobe triggers a burst of 1–16 enable pulses to the counter, with programmable idle gaps between pulses. Mode, direction and value are held stable for the whole burst, and an optional closing check pulse can follow the last step. The block sits between the keypress front end and the counter and is the only driver of the counter's `enable`, `check`, `mode`, `direction` and `value` inputs.

---
 rtl/fsm16bit_seq_if.sv | 32 +++
 rtl/fsm16bit_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fsm16bit_seq_if.sv
// fsm16bit_seq_if
// Command / counter-control bundle for the step sequencer.
//   master : front end side (drives start/abort/cmd_*, observes status and counter controls)
//   slave  : sequencer side (consumes commands, drives enable/check/mode/direction/value,
//            busy/done/pending)
interface fsm16bit_seq_if;
    logic       start;
    logic       abort;
    logic       cmd_mode;
    logic       cmd_direction;
    logic [3:0] cmd_value;
    logic [3:0] cmd_repeat;
    logic       cmd_check;
    logic       enable;
    logic       check;
    logic       mode;
    logic       direction;
    logic [3:0] value;
    logic       busy;
    logic       done;
    logic       pending;

    modport master (
        output start, abort, cmd_mode, cmd_direction, cmd_value, cmd_repeat, cmd_check,
        input  enable, check, mode, direction, value, busy, done, pending
    );

    modport slave (
        input  start, abort, cmd_mode, cmd_direction, cmd_value, cmd_repeat, cmd_check,
        output enable, check, mode, direction, value, busy, done, pending
    );
endinterface

// File: rtl/fsm16bit_seq.sv
// fsm16bit_seq
// Step sequencer for the 16-bit counter FSM: one start strobe produces a burst of
// 1..16 single-cycle enable pulses separated by GAP idle cycles, optionally closed
// by a check pulse, then a one-cycle done.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : fsm16bit_seq_if.slave (start/abort/cmd_* in; enable/check/mode/
//            direction/value/busy/done/pending out)
// Parameter:
//   GAP    : idle cycles between step pulses, 0..255
// Build option:
//   FSM16BIT_SEQ_QUEUE_EN : adds a one-deep command queue; otherwise start while
//                           busy is ignored and pending is tied 0.
module fsm16bit_seq #(
    parameter int GAP = 3
) (
    input  logic           clock,
    input  logic           reset,
    fsm16bit_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, STEP, WAIT, CHECK, DONE} state_t;

    localparam logic [7:0] GAP_C = 8'(GAP);

    state_t     state, state_nxt;
    logic [4:0] step_cnt;
    logic [7:0] gap_cnt;
    logic       lat_mode, lat_dir, lat_chk;
    logic [3:0] lat_val;
    logic       ld_cmd;   // latch command straight from the bus
    logic       ld_q;     // latch command from the queue

    // repeat field: 0 encodes 16 steps
    function automatic logic [4:0] dec_rep(input logic [3:0] r);
        return (r == 4'd0) ? 5'd16 : {1'b0, r};
    endfunction

`ifdef FSM16BIT_SEQ_QUEUE_EN
    logic       q_vld, q_mode, q_dir, q_chk;
    logic [3:0] q_val, q_rep;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_vld  <= 1'b0;
            q_mode <= 1'b0;
            q_dir  <= 1'b0;
            q_chk  <= 1'b0;
            q_val  <= 4'd0;
            q_rep  <= 4'd0;
        end else if (bus.abort) begin
            q_vld <= 1'b0;
        end else if (ld_q) begin
            // a start in the same cycle as a pop sees a full queue and is dropped
            q_vld <= 1'b0;
        end else if (bus.start && state != IDLE && !q_vld) begin
            q_vld  <= 1'b1;
            q_mode <= bus.cmd_mode;
            q_dir  <= bus.cmd_direction;
            q_chk  <= bus.cmd_check;
            q_val  <= bus.cmd_value;
            q_rep  <= bus.cmd_repeat;
        end
    end

    assign bus.pending = q_vld;
`else
    assign bus.pending = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_cmd    = 1'b0;
        ld_q      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    ld_cmd    = 1'b1;
                    state_nxt = STEP;
                end
`ifdef FSM16BIT_SEQ_QUEUE_EN
                // a command queued during the final DONE cycle launches from here
                else if (q_vld && !bus.abort) begin
                    ld_q      = 1'b1;
                    state_nxt = STEP;
                end
`endif
            end
            STEP: begin
                if (step_cnt > 5'd1) state_nxt = (GAP_C == 8'd0) ? STEP : WAIT;
                else                 state_nxt = lat_chk ? CHECK : DONE;
            end
            WAIT:  if (gap_cnt <= 8'd1) state_nxt = STEP;
            CHECK: state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
`ifdef FSM16BIT_SEQ_QUEUE_EN
                if (q_vld) begin
                    ld_q      = 1'b1;
                    state_nxt = STEP;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            state_nxt = IDLE;
            ld_q      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_mode <= 1'b0;
            lat_dir  <= 1'b0;
            lat_chk  <= 1'b0;
            lat_val  <= 4'd0;
            step_cnt <= 5'd0;
        end else if (ld_cmd) begin
            lat_mode <= bus.cmd_mode;
            lat_dir  <= bus.cmd_direction;
            lat_chk  <= bus.cmd_check;
            lat_val  <= bus.cmd_value;
            step_cnt <= dec_rep(bus.cmd_repeat);
        end
`ifdef FSM16BIT_SEQ_QUEUE_EN
        else if (ld_q) begin
            lat_mode <= q_mode;
            lat_dir  <= q_dir;
            lat_chk  <= q_chk;
            lat_val  <= q_val;
            step_cnt <= dec_rep(q_rep);
        end
`endif
        else if (state == STEP && step_cnt != 5'd0) begin
            step_cnt <= step_cnt - 5'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                   gap_cnt <= 8'd0;
        else if (state == STEP && state_nxt == WAIT)  gap_cnt <= GAP_C;
        else if (state == WAIT && gap_cnt != 8'd0)    gap_cnt <= gap_cnt - 8'd1;
    end

    // outputs decode straight from state so reset and abort silence them immediately
    assign bus.enable    = (state == STEP) || (state == CHECK);
    assign bus.check     = (state == CHECK);
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.mode      = lat_mode;
    assign bus.direction = lat_dir;
    assign bus.value     = lat_val;
endmodule
